// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-look-ahead adder/subtractor with valid/ready handshake
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int NSEG = WIDTH / SEG_W;
  localparam int NG = SEG_W / GROUP;
  logic stall;
  if (WIDTH % SEG_W != 0 || SEG_W % GROUP != 0) begin : g_bad_cfg
    $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of SEG_W and SEG_W a multiple of GROUP");
  end
  function automatic logic [SEG_W:0] cla_seg(input logic [SEG_W-1:0] a, input logic [SEG_W-1:0] b, input logic cin);
    logic [SEG_W-1:0] g, p, sm;
    logic [NG:0] gc;
    logic gg, pg, ci;
    g = a & b;
    p = a ^ b;
    sm = '0;
    gc = '0;
    gc[0] = cin;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      pg = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        pg = pg & p[j*GROUP+i];
      end
      gc[j+1] = gg | (pg & gc[j]);
    end
    for (int j = 0; j < NG; j++) begin
      ci = gc[j];
      for (int i = 0; i < GROUP; i++) begin
        sm[j*GROUP+i] = p[j*GROUP+i] ^ ci;
        ci = g[j*GROUP+i] | (p[j*GROUP+i] & ci);
      end
    end
    return {gc[NG], sm};
  endfunction
  for (genvar k = 0; k < NSEG; k++) begin : g_st
    localparam int LO = k * SEG_W;
    localparam int OPW = (k < NSEG - 1) ? WIDTH - LO - SEG_W : 1;
    logic [WIDTH-LO-1:0] a_i, b_i;
    logic [OPW-1:0] a_q, b_q;
    logic [LO+SEG_W-1:0] s_d, s_q;
    logic [SEG_W:0] r;
    logic c_i, v_i, c_q, v_q;
    if (k == 0) begin : g_head
      assign a_i = x;
      assign b_i = sub ? ~y : y;
      assign c_i = sub | c_in;
      assign v_i = in_valid;
      assign s_d = r[SEG_W-1:0];
    end else begin : g_link
      assign a_i = g_st[k-1].a_q;
      assign b_i = g_st[k-1].b_q;
      assign c_i = g_st[k-1].c_q;
      assign v_i = g_st[k-1].v_q;
      assign s_d = {r[SEG_W-1:0], g_st[k-1].s_q};
    end
    assign r = cla_seg(a_i[SEG_W-1:0], b_i[SEG_W-1:0], c_i);
    // stage register: partial sum, segment carry, unconsumed operand bits (last stage keeps MSBs for ovf)
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
        a_q <= '0;
        b_q <= '0;
      end else if (!stall) begin
        v_q <= v_i;
        c_q <= r[SEG_W];
        s_q <= s_d;
        a_q <= a_i[WIDTH-LO-1 -: OPW];
        b_q <= b_i[WIDTH-LO-1 -: OPW];
      end
    end
  end
  assign out_valid = g_st[NSEG-1].v_q;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign s = g_st[NSEG-1].s_q;
  assign c_out = g_st[NSEG-1].c_q;
  assign ovf = s[WIDTH-1] ^ g_st[NSEG-1].a_q[0] ^ g_st[NSEG-1].b_q[0] ^ c_out;
  assign zero = ~|s;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed and random checks of the pipelined CLA adder
module tb_cla_pipe_adder;
  typedef struct packed {
    logic [15:0] s;
    logic c;
    logic o;
    logic z;
  } res_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, c_in = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, c_out, ovf, zero;
  logic [15:0] x = '0, y = '0, s;
  int n_chk = 0, n_err = 0;
  res_t q[$];
  res_t e;
  logic [15:0] got[$];
  int idx, sent, cycles;
  logic acc;
  always #5 clk = ~clk;
  cla_pipe_adder #(.WIDTH(16), .SEG_W(8), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .c_out(c_out), .ovf(ovf), .zero(zero)
  );
  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    logic [15:0] bb;
    logic [16:0] f;
    res_t r;
    bb = sb ? ~b : b;
    f = {1'b0, a} + {1'b0, bb} + {16'd0, sb | ci};
    r.s = f[15:0];
    r.c = f[16];
    r.o = (a[15] == bb[15]) && (f[15] != a[15]);
    r.z = (f[15:0] == 16'd0);
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // scoreboard: transfers happen at the next rising edge, so sample both sides mid-cycle
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          check("sb_s", {16'd0, s}, {16'd0, e.s});
          check("sb_c", {31'd0, c_out}, {31'd0, e.c});
          check("sb_ovf", {31'd0, ovf}, {31'd0, e.o});
          check("sb_zero", {31'd0, zero}, {31'd0, e.z});
        end
      end
      if (in_valid && in_ready) q.push_back(model(x, y, c_in, sub));
    end
  end
  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic sb, input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    x = a;
    y = b;
    c_in = ci;
    sub = sb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    step();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_s"}, {16'd0, s}, {16'd0, es});
    check({tag, "_c"}, {31'd0, c_out}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
  endtask
  initial begin
    repeat (2) step();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_c", {31'd0, c_out}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    directed("add", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    directed("chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    directed("sub_neg", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("seg_cross", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    directed("sub_zero", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    step();
    idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid = idx < 5;
      x = 16'(idx + 1);
      y = 16'(idx + 1);
      c_in = 1'b0;
      sub = 1'b0;
      #1;
      if (cyc >= 3 && cyc <= 5) check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) got.push_back(s);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_count", got.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) check("bp_order", {16'd0, got[i]}, 32'(2 * (i + 1)));
    out_ready = 1'b0;
    x = 16'd1;
    y = 16'd1;
    in_valid = 1'b1;
    step();
    x = 16'd2;
    y = 16'd2;
    step();
    in_valid = 1'b0;
    check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mid_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_in_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    directed("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    step();
    sent = 0;
    cycles = 0;
    in_valid = 1'b1;
    x = 16'($urandom);
    y = 16'($urandom);
    c_in = 1'($urandom);
    sub = 1'($urandom);
    while (sent < 10000 && cycles < 60000) begin
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (acc) begin
        sent++;
        x = 16'($urandom);
        y = 16'($urandom);
        c_in = 1'($urandom);
        sub = 1'($urandom);
      end
    end
    check("rand_sent", sent, 32'd10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    check("drain_empty", q.size(), 32'd0);
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
